// File: rtl/prog_loader_pkg.sv
// Purpose: shared types and constants for the UART program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   state_e           loader FSM states
//   DEFAULT_EOP_WORD  terminator word that ends a program image
//   IDX_W / LANES     byte-lane index width and lanes per 32-bit word
package prog_loader_pkg;

    // LOAD  : collecting bytes of the next word
    // WRITE : holding a write request until the memory grants it
    // DONE  : program complete, core released from reset
    // ERR   : load aborted (overflow or skid collision)
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    // Terminator word; recognised on the 4th byte and never written.
    localparam logic [31:0] DEFAULT_EOP_WORD = 32'h0000_0FFF;

    // Four byte lanes per little-endian word, addressed by a 2-bit index.
    localparam int LANES = 4;
    localparam int IDX_W = 2;

endpackage

// File: rtl/prog_word_asm.sv
// Purpose: assembles UART bytes into little-endian 32-bit words, with a one-byte skid buffer.
// Latency: word_valid/word are combinational on the strobe carrying the 4th byte.
// Backpressure: while hold_en is high one strobe is parked in the skid; a second one raises collide.
//
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   load_en         controller is collecting bytes (LOAD)
//   hold_en         controller is stalled on a memory write (WRITE)
//   clr             restart the byte index (write handshake completed)
//   rx_vld, rx_dat  one-cycle byte strobe and its data
//   word_valid      the current strobe completes a word
//   word            completed word: {rx_dat, lane 2, lane 1, lane 0}
//   collide         a strobe arrived during a stall while the skid is occupied
module prog_word_asm
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic        hold_en,
    input  logic        clr,
    input  logic        rx_vld,
    input  logic [7:0]  rx_dat,
    output logic        word_valid,
    output logic [31:0] word,
    output logic        collide
);

    logic [IDX_W-1:0] idx_q;
    logic [2:0][7:0]  lane_q;      // lanes 0..2; lane 3 is taken live from rx_dat
    logic [7:0]       skid_dat_q;
    logic             skid_vld_q;

    logic drain;       // skid byte is consumed this cycle
    logic take_rx;     // strobe is accepted into the lane register this cycle
    logic park;        // strobe is parked in the skid this cycle

    assign drain   = load_en && skid_vld_q;
    assign take_rx = load_en && rx_vld;
    assign park    = hold_en && rx_vld && !skid_vld_q;
    assign collide = hold_en && rx_vld &&  skid_vld_q;

    // A draining cycle places at most two bytes (lanes 0 and 1), so a word can
    // only complete on a plain accepted strobe at the last lane.
    assign word_valid = take_rx && !skid_vld_q && (idx_q == IDX_W'(LANES - 1));
    assign word       = {rx_dat, lane_q[2], lane_q[1], lane_q[0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q      <= '0;
            lane_q     <= '0;
            skid_dat_q <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            // Byte index and lane register.
            if (clr) begin
                idx_q <= '0;
            end else if (drain) begin
                // The skid only fills during a write stall, and the index is
                // zero on return to LOAD, so the parked byte is always byte 0.
                // A coincident strobe lands behind it as byte 1.
                lane_q[0] <= skid_dat_q;
                if (rx_vld) begin
                    lane_q[1] <= rx_dat;
                    idx_q     <= IDX_W'(2);
                end else begin
                    idx_q     <= IDX_W'(1);
                end
            end else if (take_rx) begin
                unique case (idx_q)
                    2'd0:    lane_q[0] <= rx_dat;
                    2'd1:    lane_q[1] <= rx_dat;
                    2'd2:    lane_q[2] <= rx_dat;
                    default: ;  // last lane is consumed live from rx_dat
                endcase
                idx_q <= idx_q + IDX_W'(1);
            end

            // Skid buffer: filled by the first strobe of a stall (including
            // the grant cycle), emptied on the first LOAD cycle afterwards.
            if (drain) begin
                skid_vld_q <= 1'b0;
            end else if (park) begin
                skid_vld_q <= 1'b1;
                skid_dat_q <= rx_dat;
            end
        end
    end

endmodule

// File: rtl/prog_loader_ctrl.sv
// Purpose: UART program loader; writes assembled words into instruction memory, holds core in reset until EOP.
// Latency: 4th byte at cycle N -> mem_req_o from N+1; grant in N+1 -> request drops, count increments at N+2.
// Backpressure: memory stalls are absorbed by a one-byte skid; a second byte during a stall aborts to ERR.
//
// Ports:
//   clk_i, rst_ni               clock and synchronous active-low reset
//   rx_valid_i, rx_byte_i       byte strobe from the UART receiver
//   mem_req_o, mem_gnt_i        write request / grant; transfer on req && gnt
//   mem_we_o                    write enable (same as mem_req_o)
//   mem_addr_o, mem_wdata_o     byte address BASE_ADDR + 4*word_cnt_o, assembled word
//   core_rst_no                 core reset, released only once the program is loaded
//   done_o, err_o               sticky load complete / load failed
//   word_cnt_o                  words written so far
module prog_loader_ctrl
    import prog_loader_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] EOP_WORD  = DEFAULT_EOP_WORD
)(
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         rx_valid_i,
    input  logic [7:0]                   rx_byte_i,
    output logic                         mem_req_o,
    input  logic                         mem_gnt_i,
    output logic                         mem_we_o,
    output logic [31:0]                  mem_addr_o,
    output logic [31:0]                  mem_wdata_o,
    output logic                         core_rst_no,
    output logic                         done_o,
    output logic                         err_o,
    output logic [$clog2(MEM_WORDS):0]   word_cnt_o
);

    localparam int CNT_W = $clog2(MEM_WORDS) + 1;

    state_e state_q;
    state_e state_d;

    logic        word_valid;
    logic [31:0] word;
    logic        collide;
    logic        xfer;        // write handshake completes this cycle

    // Next-cycle values of the registered control outputs.
    logic req_d;
    logic done_d;
    logic err_d;
    logic core_rst_n_d;

    assign xfer     = mem_req_o && mem_gnt_i;
    assign mem_we_o = mem_req_o;

    prog_word_asm u_word_asm (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .load_en    (state_q == ST_LOAD),
        .hold_en    (state_q == ST_WRITE),
        .clr        (xfer),
        .rx_vld     (rx_valid_i),
        .rx_dat     (rx_byte_i),
        .word_valid (word_valid),
        .word       (word),
        .collide    (collide)
    );

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_LOAD;
            mem_req_o   <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            core_rst_no <= 1'b0;
            mem_addr_o  <= BASE_ADDR;
            mem_wdata_o <= '0;
            word_cnt_o  <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_o   <= req_d;
            done_o      <= done_d;
            err_o       <= err_d;
            core_rst_no <= core_rst_n_d;

            // Capture the word only when it will actually be written, so the
            // data bus stays frozen for the whole request.
            if (state_q == ST_LOAD && state_d == ST_WRITE) begin
                mem_wdata_o <= word;
            end

            // The address tracks the count so it is already registered when
            // the next request goes out. A handshake that coincides with a
            // collision still completed at the memory and is counted.
            if (xfer) begin
                word_cnt_o <= word_cnt_o + CNT_W'(1);
                mem_addr_o <= mem_addr_o + 32'd4;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD: begin
                if (word_valid) begin
                    // Terminator wins over overflow: a full memory followed
                    // by EOP is a complete program.
                    if (word == EOP_WORD) begin
                        state_d = ST_DONE;
                    end else if (word_cnt_o == CNT_W'(MEM_WORDS)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (collide) begin
                    state_d = ST_ERR;
                end else if (mem_gnt_i) begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (from the next state, so outputs leave flops)
    // ------------------------------------------------------------------
    always_comb begin
        req_d        = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        core_rst_n_d = 1'b0;
        unique case (state_d)
            ST_LOAD:  ;
            ST_WRITE: req_d = 1'b1;
            ST_DONE: begin
                done_d       = 1'b1;
                core_rst_n_d = 1'b1;
            end
            ST_ERR:   err_d = 1'b1;
            default:  err_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_prog_loader_ctrl.sv
module tb_prog_loader_ctrl;

    localparam int unsigned MW   = 4;
    localparam int          CW   = $clog2(MW) + 1;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [31:0] EOP  = 32'h0000_0FFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_vld = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          gnt = 1'b0;
    logic          req, we, core_rst_n, done, err;
    logic [31:0]   addr, wdata;
    logic [CW-1:0] cnt;

    always #5 clk = ~clk;

    prog_loader_ctrl #(
        .MEM_WORDS (MW),
        .BASE_ADDR (BASE),
        .EOP_WORD  (EOP)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_valid_i  (rx_vld),
        .rx_byte_i   (rx_byte),
        .mem_req_o   (req),
        .mem_gnt_i   (gnt),
        .mem_we_o    (we),
        .mem_addr_o  (addr),
        .mem_wdata_o (wdata),
        .core_rst_no (core_rst_n),
        .done_o      (done),
        .err_o       (err),
        .word_cnt_o  (cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Stimulus schedule: byte arrival cycles/values and per-write grant delays.
    int         sch_cyc[$];
    logic [7:0] sch_byte[$];
    int         sch_dly[$];
    int         last_cyc;

    // Reference model output: one entry per write attempt.
    int          at_start[$];
    int          at_end[$];
    int          at_gnt[$];
    logic [31:0] at_addr[$];
    logic [31:0] at_data[$];
    int          exp_state;   // 0 loading, 1 done, 2 error
    int          exp_term;    // first cycle done/err is visible

    // Observed completed writes.
    logic [31:0] obs_wa[$];
    logic [31:0] obs_wd[$];
    logic        req_seen;

    task automatic new_sched();
        sch_cyc.delete();
        sch_byte.delete();
        sch_dly.delete();
        last_cyc = 0;
    endtask

    task automatic push_byte(input logic [7:0] b, input int gap);
        last_cyc += gap;
        sch_cyc.push_back(last_cyc);
        sch_byte.push_back(b);
    endtask

    task automatic push_word(input logic [31:0] w, input int gap0, input int gap);
        push_byte(w[7:0], gap0);
        push_byte(w[15:8], gap);
        push_byte(w[23:16], gap);
        push_byte(w[31:24], gap);
    endtask

    // Timeline model: every four consecutive bytes form a word whose 4th byte
    // arrives at cycle t. A write is requested over cycles t+1 .. t+1+delay;
    // at most one byte may arrive in that window, a second one aborts.
    task automatic run_model();
        int i, k, n, t, g, hits, second;
        logic [31:0] w;
        at_start.delete(); at_end.delete(); at_gnt.delete();
        at_addr.delete();  at_data.delete();
        exp_state = 0;
        exp_term  = -1;
        k = 0;
        i = 0;
        n = sch_cyc.size();
        while (exp_state == 0 && i + 3 < n) begin
            w = {sch_byte[i+3], sch_byte[i+2], sch_byte[i+1], sch_byte[i]};
            t = sch_cyc[i+3];
            if (w == EOP) begin
                exp_state = 1;
                exp_term  = t + 1;
            end else if (k == int'(MW)) begin
                exp_state = 2;
                exp_term  = t + 1;
            end else begin
                g = t + 1 + sch_dly[k];
                hits   = 0;
                second = -1;
                for (int j = i + 4; j < n; j++) begin
                    if (sch_cyc[j] >= t + 1 && sch_cyc[j] <= g) begin
                        hits++;
                        if (hits == 2) second = sch_cyc[j];
                    end
                end
                at_start.push_back(t + 1);
                at_addr.push_back(BASE + 32'(4 * k));
                at_data.push_back(w);
                if (second < 0 || second == g) begin
                    at_end.push_back(g);
                    at_gnt.push_back(g);
                    k++;
                end else begin
                    at_end.push_back(second);
                    at_gnt.push_back(-1);
                end
                if (second >= 0) begin
                    exp_state = 2;
                    exp_term  = second + 1;
                end
                i += 4;
            end
        end
    endtask

    function automatic int active_at(input int c);
        int r;
        r = -1;
        foreach (at_start[j]) if (c >= at_start[j] && c <= at_end[j]) r = j;
        return r;
    endfunction

    // Expected {cnt, req, we, done, err, core_rst_n} during cycle c.
    function automatic logic [31:0] exp_vec(input int c);
        int   n;
        logic r, d, e;
        n = 0;
        foreach (at_gnt[j]) if (at_gnt[j] >= 0 && at_gnt[j] < c) n++;
        r = (active_at(c) >= 0);
        d = (exp_state == 1 && c >= exp_term);
        e = (exp_state == 2 && c >= exp_term);
        return 32'({CW'(n), r, r, d, e, d});
    endfunction

    task automatic run_scenario(input string name, input int abort_at);
        int   ncyc, ptr, gi, hold, dly, a;
        logic aborted;
        run_model();
        obs_wa.delete();
        obs_wd.delete();
        req_seen = 1'b0;

        rst_n = 1'b0; rx_vld = 1'b0; gnt = 1'b0; rx_byte = 8'h00;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq({name, " reset ctrl"}, 32'({cnt, req, we, done, err, core_rst_n}), 32'd0);
        check_eq({name, " reset addr"}, addr, BASE);
        check_eq({name, " reset wdata"}, wdata, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        ncyc = (abort_at >= 0) ? abort_at + 4 : last_cyc + 80;
        ptr = 0; gi = 0; hold = 0;
        for (int c = 0; c < ncyc; c++) begin
            aborted = (abort_at >= 0 && c > abort_at);
            if (ptr < sch_cyc.size() && sch_cyc[ptr] == c) begin
                rx_vld  = 1'b1;
                rx_byte = sch_byte[ptr];
                ptr++;
            end else begin
                rx_vld  = 1'b0;
                rx_byte = 8'($urandom);
            end
            dly = (gi < sch_dly.size()) ? sch_dly[gi] : 0;
            if (req) gnt = (hold >= dly);
            else     gnt = ($urandom_range(0, 3) == 0);
            if (abort_at >= 0 && c == abort_at) rst_n = 1'b0;
            if (aborted) begin
                gnt    = 1'b0;
                rx_vld = 1'b0;
            end

            @(negedge clk);
            if (req) req_seen = 1'b1;
            if (req && gnt) begin
                obs_wa.push_back(addr);
                obs_wd.push_back(wdata);
            end
            if (aborted) begin
                check_eq($sformatf("%s ctrl after reset c%0d", name, c),
                         32'({cnt, req, we, done, err, core_rst_n}), 32'd0);
                check_eq($sformatf("%s addr after reset c%0d", name, c), addr, BASE);
            end else begin
                check_eq($sformatf("%s ctrl c%0d", name, c),
                         32'({cnt, req, we, done, err, core_rst_n}), exp_vec(c));
                a = active_at(c);
                if (a >= 0) begin
                    check_eq($sformatf("%s addr c%0d", name, c), addr, at_addr[a]);
                    check_eq($sformatf("%s wdata c%0d", name, c), wdata, at_data[a]);
                end
            end

            if (req && gnt) begin
                gi++;
                hold = 0;
            end else if (req) begin
                hold++;
            end else begin
                hold = 0;
            end
            @(posedge clk);
            #1;
        end
        rx_vld = 1'b0;
        gnt    = 1'b0;
    endtask

    initial begin
        int nw, gmax, dmax;
        logic [31:0] w;

        // Two instructions then EOP, no grant wait.
        new_sched();
        push_word(32'h0000_0013, 2, 2);
        push_word(32'h0010_0093, 3, 2);
        push_word(EOP, 3, 2);
        repeat (8) sch_dly.push_back(0);
        run_scenario("basic", -1);
        check_eq("basic nwrites", obs_wd.size(), 2);
        if (obs_wd.size() >= 2) begin
            check_eq("basic w0 data", obs_wd[0], 32'h0000_0013);
            check_eq("basic w0 addr", obs_wa[0], BASE);
            check_eq("basic w1 data", obs_wd[1], 32'h0010_0093);
            check_eq("basic w1 addr", obs_wa[1], BASE + 32'd4);
        end
        check_eq("basic done", {done, core_rst_n}, 2'b11);
        check_eq("basic cnt", cnt, 2);

        // Grant withheld 5 cycles with one byte parked in the skid.
        new_sched();
        push_word(32'h1122_3344, 2, 1);    // bytes at 2..5, request 6..11
        push_byte(8'hD4, 3);               // cycle 8, inside the stall
        push_byte(8'hC3, 5);
        push_byte(8'hB2, 1);
        push_byte(8'hA1, 1);
        push_word(EOP, 3, 1);
        sch_dly.push_back(5);
        repeat (7) sch_dly.push_back(0);
        run_scenario("stall", -1);
        check_eq("stall nwrites", obs_wd.size(), 2);
        if (obs_wd.size() >= 2) check_eq("stall skid word", obs_wd[1], 32'hA1B2_C3D4);
        check_eq("stall done", done, 1);

        // Two strobes during a stalled write.
        new_sched();
        push_word(32'hCAFE_0001, 2, 1);    // request from cycle 6
        push_byte(8'h11, 2);               // parked
        push_byte(8'h22, 2);               // collision
        push_word(32'h5555_AAAA, 2, 2);
        repeat (8) sch_dly.push_back(6);
        run_scenario("collide", -1);
        check_eq("collide err", {err, core_rst_n, done}, 3'b100);
        check_eq("collide cnt", cnt, 0);
        check_eq("collide nwrites", obs_wd.size(), 0);

        // Five non-EOP words into a four-word memory.
        new_sched();
        for (int k = 0; k < 5; k++) push_word(32'h0100_0000 * k + 32'h33, 2, 2);
        repeat (8) sch_dly.push_back(0);
        run_scenario("overflow", -1);
        check_eq("overflow nwrites", obs_wd.size(), 4);
        check_eq("overflow err", err, 1);
        check_eq("overflow cnt", cnt, 4);

        // EOP as the first word, trailing bytes ignored.
        new_sched();
        push_word(EOP, 2, 1);
        push_word(32'h0000_0013, 2, 1);
        repeat (8) sch_dly.push_back(0);
        run_scenario("eop_first", -1);
        check_eq("eop_first req_seen", req_seen, 0);
        check_eq("eop_first done", {done, core_rst_n}, 2'b11);
        check_eq("eop_first cnt", cnt, 0);

        // Reset while the third write is stalled, then reload.
        new_sched();
        for (int k = 0; k < 3; k++) push_word(32'hDEAD_0000 + k, 2, 2);
        sch_dly.push_back(0);
        sch_dly.push_back(0);
        repeat (6) sch_dly.push_back(6);
        run_scenario("abort", 27);          // third request spans cycles 25..31
        check_eq("abort nwrites", obs_wd.size(), 2);
        new_sched();
        push_word(32'h0000_0513, 2, 1);
        push_word(EOP, 2, 1);
        repeat (8) sch_dly.push_back(0);
        run_scenario("reload", -1);
        check_eq("reload nwrites", obs_wd.size(), 1);
        if (obs_wd.size() >= 1) check_eq("reload addr", obs_wa[0], BASE);
        check_eq("reload done", done, 1);

        // Randomized programs.
        for (int s = 0; s < 20; s++) begin
            new_sched();
            nw   = $urandom_range(0, 6);
            gmax = $urandom_range(1, 10);
            dmax = $urandom_range(0, 8);
            for (int k = 0; k < nw; k++) begin
                w = $urandom;
                if ($urandom_range(0, 7) == 0) w = EOP ^ (32'h1 << $urandom_range(0, 31));
                push_word(w, $urandom_range(1, gmax), $urandom_range(1, gmax));
            end
            if ($urandom_range(0, 1) == 1) push_word(EOP, $urandom_range(1, gmax), $urandom_range(1, gmax));
            for (int k = $urandom_range(0, 3); k > 0; k--) push_byte(8'($urandom), $urandom_range(1, gmax));
            for (int k = 0; k < 8; k++) sch_dly.push_back($urandom_range(0, dmax));
            run_scenario($sformatf("rand%0d", s), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
